bm_mult_arbiter: RTL

BM_MULT_ARBITER -- requirements
Module: bm_mult_arbiter

---
 rtl/bm_mult_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/bm_mult_arbiter.sv
// Two-requester round-robin front end sharing one block-mantissa multiplier.
// The product is registered one cycle after the grant; the output is a single stage that reloads at full rate.
module bm_mult_arbiter #(
   parameter int E  = 3,
   parameter int M  = 4,
   parameter int SB = 3,
   localparam int BMW = 1 + E + M,
   localparam int RW  = 2*M + E + 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [BMW-1:0] req0_bm1,
   input  logic [BMW-1:0] req0_bm2,
   input  logic [BMW-1:0] req1_bm1,
   input  logic [BMW-1:0] req1_bm2,
   input  logic [SB-1:0]  req0_sb1,
   input  logic [SB-1:0]  req0_sb2,
   input  logic [SB-1:0]  req1_sb1,
   input  logic [SB-1:0]  req1_sb2,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_id,
   output logic [RW-1:0]  out_result,
   output logic [SB-1:0]  out_sb,
   output logic           out_ovf,
   output logic [7:0]     op_count
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [E+1:0] EXP_MAX = (E+2)'((1 << E) - 1);

   state_t         state_q;
   logic           ptr_q;
   logic           load;
   logic           gnt_vld;
   logic           gnt_id;
   logic [BMW-1:0] bm1;
   logic [BMW-1:0] bm2;
   logic [SB-1:0]  sb1;
   logic [SB-1:0]  sb2;
   logic [E+1:0]   e1x;
   logic [E+1:0]   e2x;
   logic [E+1:0]   esum;
   logic [2*M+1:0] m1x;
   logic [2*M+1:0] m2x;
   logic [2*M+1:0] mprod;
   logic [RW-1:0]  result_d;
   logic [SB-1:0]  sb_d;
   logic           ovf_d;

   assign out_valid = (state_q == FULL);

   always_comb begin
      load    = (state_q == EMPTY) || out_ready;
      gnt_vld = !rst && load && (|req_valid);
      gnt_id  = (&req_valid) ? ptr_q : req_valid[1];
      req_ready = 2'b00;
      if (gnt_vld) begin
         req_ready = gnt_id ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      bm1 = gnt_id ? req1_bm1 : req0_bm1;
      bm2 = gnt_id ? req1_bm2 : req0_bm2;
      sb1 = gnt_id ? req1_sb1 : req0_sb1;
      sb2 = gnt_id ? req1_sb2 : req0_sb2;

      // Two guard bits keep the unwrapped exponent sum exact for the overflow test.
      e1x  = {{2{bm1[M+E-1]}}, bm1[M+E-1:M]};
      e2x  = {{2{bm2[M+E-1]}}, bm2[M+E-1:M]};
      esum = e1x + e2x + (E+2)'(2);
      ovf_d = $signed(esum) > $signed(EXP_MAX);

      m1x   = {{(M+1){1'b0}}, 1'b1, bm1[M-1:0]};
      m2x   = {{(M+1){1'b0}}, 1'b1, bm2[M-1:0]};
      mprod = m1x * m2x;

      result_d = {bm1[BMW-1] ^ bm2[BMW-1], esum[E:0], mprod};
      sb_d     = sb1 + sb2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         ptr_q      <= 1'b0;
         out_result <= '0;
         out_sb     <= '0;
         out_ovf    <= 1'b0;
         out_id     <= 1'b0;
         op_count   <= 8'd0;
      end else begin
         if (gnt_vld) begin
            state_q    <= FULL;
            ptr_q      <= ~gnt_id;
            out_result <= result_d;
            out_sb     <= sb_d;
            out_ovf    <= ovf_d;
            out_id     <= gnt_id;
         end else if (out_ready) begin
            state_q <= EMPTY;
         end
         if (out_valid && out_ready) begin
            op_count <= op_count + 8'd1;
         end
      end
   end

endmodule
